ofs_fim_pcie_hdr_merge: RTL and testbench
=========================================

# ofs_fim_pcie_hdr_merge

Merges an out-of-band PCIe SS header stream and a separate bus-aligned payload stream into one in-band PCIe SS TLP stream. Each TLP's header is placed at tdata[0] of its SOP beat, and the payload is shifted up by one header width across beats. The block sits on the TX path, between AFU-side logic that produces split header/data streams and the PCIe SS TX port. It is the inverse of the header-extract shim on the RX path.

## Interface
Parameters:
- PL_DEPTH_OUT, default 1: depth of the output ofs_fim_axis_pipeline (0 is legal, giving a combinational pass-through).

Ports:
- clk  in  1  clock; equals the clk of all three interfaces.
- rst_n  in  1  reset; synchronous, active-low.
- hdr_stream_source  pcie_ss_axis_if.sink  TDATA_WIDTH  one header per transfer.
  - Header occupies tdata[HDR_WIDTH-1:0].
  - tlast is ignored.
  - tuser_vendor travels with the header.
- data_stream_source  pcie_ss_axis_if.sink  TDATA_WIDTH  payload, bus-aligned.
  - tkeep is contiguous from bit 0.
  - tlast marks the final payload beat.
- stream_sink  pcie_ss_axis_if.source  TDATA_WIDTH  merged in-band TLP stream.

Derived widths:
- TDATA_WIDTH and TUSER_WIDTH are taken from stream_sink.
- HDR_WIDTH = $bits(pcie_ss_hdr_pkg::PCIe_PUReqHdr_t).
- DW = TDATA_WIDTH - HDR_WIDTH (payload bits that fit beside a header). DK = DW/8 (the matching tkeep bit count).
- TDATA_WIDTH must be greater than HDR_WIDTH. An elaboration-time $error fires otherwise.

## Operation
A header carries payload iff pcie_ss_hdr_pkg::func_has_data(fmt_type) is true. The FSM has three states.

- IDLE
  - Header without payload, when it fires:
    - Emit one beat: tdata = {'0, hdr}, tkeep = HDR_WIDTH/8 ones, tlast = 1.
    - Stay in IDLE.
  - Header with payload: wait until header and payload beat d0 are both valid, then consume both in the same cycle.
  - Emit {d0[0 +: DW], hdr}, with tkeep = {d0.tkeep[0 +: DK], hdr ones}.
  - Save the carry register: d0[DW +: HDR_WIDTH] and its tkeep.
  - Next state:
    - If d0.tlast and !d0.tkeep[DK], set tlast and stay in IDLE.
    - Else if d0.tlast (payload spills past the header beat), go to FLUSH.
    - Else go to DATA.
- DATA: each accepted payload beat dn emits {dn[0 +: DW], carry} with tkeep {dn.tkeep[0 +: DK], carry_keep}, then updates the carry from dn.
  - dn.tlast and !dn.tkeep[DK]: set tlast and go to IDLE.
  - dn.tlast and dn.tkeep[DK]: go to FLUSH.
- FLUSH: emit {'0, carry} with tkeep {'0, carry_keep} and tlast = 1, consuming no input. Go to IDLE.

Fixed output rules:
- stream_sink.tuser_vendor equals the header's tuser_vendor on the SOP beat and '0 on every other beat.
- Any payload beat arriving while in IDLE without a header is held; it is never dropped.

Handshakes:
- hdr_stream_source.tready = IDLE && out_ready && (!has_data || data_stream_source.tvalid).
- data_stream_source.tready = out_ready && ((IDLE && hdr valid && has_data) || DATA).
- Neither tready is asserted in FLUSH.
- A tready may depend on the other stream's tvalid. No tvalid depends on a tready.

## Timing
- Latency: PL_DEPTH_OUT cycles from input acceptance to the corresponding stream_sink beat.
- Throughput:
  - One output beat per cycle in steady state.
  - Header-only TLPs can issue back to back, one per cycle.
  - FLUSH costs exactly one bubble on the input side.
- Reset:
  - FSM goes to IDLE and the carry keep is cleared.
  - stream_sink.tvalid = 0, and both input treadys = 0 while rst_n = 0.
- Reset mid-packet discards the partial TLP. After release, the first output beat is always a SOP.
- Output backpressure freezes all state. The carry register updates only on an accepted beat.

## Configuration
- OFS_FIM_PCIE_HDR_MERGE_SKID_IN_EN
  - Defined: an ofs_fim_axis_pipeline skid buffer is inserted on each of the two inputs. This breaks the tready paths and adds 1 cycle of latency.
  - Undefined: the inputs connect directly to the FSM.
  - Functional output ordering is identical either way.

## Structure
- No new package. HDR_WIDTH, the header typedefs and func_has_data all come from pcie_ss_hdr_pkg.
- The FSM state enum is local to the module.
- Sub-module: ofs_fim_axis_pipeline, used for the output stage (PL_DEPTH_OUT) and for the optional input skids.

## Test plan
All scenarios use TDATA_WIDTH = 512 and HDR_WIDTH = 256, so DW = 256 and DK = 32.
- Header-only MRd → one beat: tdata[255:0] = hdr, tkeep = 64'h0000_0000_FFFF_FFFF, tlast = 1.
- MWr with a 32B payload (d0.tkeep = 32 ones, tlast) → one beat: {d0[255:0], hdr}, tkeep all ones, tlast = 1.
- MWr with a 64B payload (one full beat) → beat {d0 low, hdr}, then flush beat {0, d0 high} with tkeep = 64'hFFFF_FFFF and tlast = 1.
- MWr with 96B (d0 full, d1 = 32B tlast) → beat {d0 low, hdr}, then {d1 low, d0 high} with tlast = 1. No flush beat.
- Random stream_sink.tready and random input valids over 1000 mixed TLPs → byte-exact match against the reference model; no beat lost or duplicated.
- rst_n asserted during the DATA state → tvalid = 0 the next cycle; a subsequent header-only TLP emerges as a clean SOP/EOP beat.

Source files
------------

// File: rtl/pcie_ss_hdr_pkg.sv
// pcie_ss_hdr_pkg: PCIe SS power-user header layout and TLP format helpers.
package pcie_ss_hdr_pkg;

    localparam logic [7:0] M_RD32  = 8'h00;
    localparam logic [7:0] M_RD    = 8'h20;
    localparam logic [7:0] M_WR32  = 8'h40;
    localparam logic [7:0] M_WR    = 8'h60;
    localparam logic [7:0] DM_CPL  = 8'h0A;
    localparam logic [7:0] DM_CPLD = 8'h4A;

    // fmt_type sits in the first byte on the wire, so it is the least significant field
    typedef struct packed {
        logic [247:0] body;
        logic [7:0]   fmt_type;
    } PCIe_PUReqHdr_t;

    // Fmt bit 1 (fmt_type[6]) set means the TLP carries a data payload
    function automatic logic func_has_data(input logic [7:0] fmt_type);
        return (fmt_type & 8'h40) != 8'h00;
    endfunction

endpackage

// File: rtl/pcie_ss_axis_if.sv
// pcie_ss_axis_if: AXI-Stream bundle used between PCIe SS TX/RX blocks.
interface pcie_ss_axis_if #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [USER_W-1:0] tuser_vendor;

    modport source (output tvalid, tlast, tdata, tkeep, tuser_vendor, input tready);
    modport sink   (input tvalid, tlast, tdata, tkeep, tuser_vendor, output tready);
endinterface

// File: rtl/ofs_fim_axis_pipeline.sv
// ofs_fim_axis_pipeline: PL_DEPTH chained full-throughput skid stages; depth 0 is a wire.
module ofs_fim_axis_pipeline #(
    parameter int PL_DEPTH = 1
) (
    input logic            clk,
    input logic            rst_n,
    pcie_ss_axis_if.sink   axis_s,
    pcie_ss_axis_if.source axis_m
);
    localparam int DW = $bits(axis_m.tdata);
    localparam int TW = $bits(axis_m.tuser_vendor);
    localparam int W  = 1 + TW + DW/8 + DW;

    logic [W-1:0]      pd [PL_DEPTH+1];
    logic [PL_DEPTH:0] pv;
    logic [PL_DEPTH:0] pr;

    assign pd[0] = {axis_s.tlast, axis_s.tuser_vendor, axis_s.tkeep, axis_s.tdata};
    assign pv[0] = axis_s.tvalid;
    assign axis_s.tready = pr[0];
    assign {axis_m.tlast, axis_m.tuser_vendor, axis_m.tkeep, axis_m.tdata} = pd[PL_DEPTH];
    assign axis_m.tvalid = pv[PL_DEPTH];
    assign pr[PL_DEPTH] = axis_m.tready;

    for (genvar i = 0; i < PL_DEPTH; i++) begin : g_stage
        logic [W-1:0] m;
        logic [W-1:0] s;
        logic         mv;
        logic         sv;
        // Upstream ready comes from the skid slot only, so it never sees downstream ready
        assign pr[i]   = !sv && rst_n;
        assign pv[i+1] = mv;
        assign pd[i+1] = m;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                mv <= 1'b0;
                sv <= 1'b0;
            end else if (!mv || pr[i+1]) begin
                mv <= sv || pv[i];
                m  <= sv ? s : pd[i];
                sv <= 1'b0;
            end else if (pv[i] && !sv) begin
                s  <= pd[i];
                sv <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/ofs_fim_pcie_hdr_merge.sv
// ofs_fim_pcie_hdr_merge: merges an out-of-band header stream and a bus-aligned payload stream into an in-band TLP stream.
// Define OFS_FIM_PCIE_HDR_MERGE_SKID_IN_EN to put a skid buffer on both inputs.
module ofs_fim_pcie_hdr_merge
    import pcie_ss_hdr_pkg::*;
#(
    parameter int PL_DEPTH_OUT = 1
) (
    input logic            clk,
    input logic            rst_n,
    pcie_ss_axis_if.sink   hdr_stream_source,
    pcie_ss_axis_if.sink   data_stream_source,
    pcie_ss_axis_if.source stream_sink
);
    localparam int TDATA_WIDTH = $bits(stream_sink.tdata);
    localparam int TUSER_WIDTH = $bits(stream_sink.tuser_vendor);
    localparam int HDR_WIDTH   = $bits(PCIe_PUReqHdr_t);
    localparam int DW = TDATA_WIDTH - HDR_WIDTH;
    localparam int DK = DW/8;
    localparam int HK = HDR_WIDTH/8;

`ifdef OFS_FIM_PCIE_HDR_MERGE_SKID_IN_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    if (TDATA_WIDTH <= HDR_WIDTH) begin : g_width_chk
        $error("ofs_fim_pcie_hdr_merge: TDATA_WIDTH must exceed HDR_WIDTH");
    end

    pcie_ss_axis_if #(.DATA_W(TDATA_WIDTH), .USER_W(TUSER_WIDTH)) h ();
    pcie_ss_axis_if #(.DATA_W(TDATA_WIDTH), .USER_W(TUSER_WIDTH)) d ();
    pcie_ss_axis_if #(.DATA_W(TDATA_WIDTH), .USER_W(TUSER_WIDTH)) o ();

    ofs_fim_axis_pipeline #(.PL_DEPTH(SKID)) u_hdr_in (.clk(clk), .rst_n(rst_n), .axis_s(hdr_stream_source), .axis_m(h));
    ofs_fim_axis_pipeline #(.PL_DEPTH(SKID)) u_data_in (.clk(clk), .rst_n(rst_n), .axis_s(data_stream_source), .axis_m(d));
    ofs_fim_axis_pipeline #(.PL_DEPTH(PL_DEPTH_OUT)) u_out (.clk(clk), .rst_n(rst_n), .axis_s(o), .axis_m(stream_sink));

    logic [1:0]           st;
    logic [HDR_WIDTH-1:0] carry;
    logic [HK-1:0]        carry_keep;
    PCIe_PUReqHdr_t       hdr;
    logic has_data, idle, out_ready, out_valid, fire, spill, pad;
    logic unused_ok;

    assign hdr       = h.tdata[HDR_WIDTH-1:0];
    assign has_data  = func_has_data(hdr.fmt_type);
    assign idle      = st == IDLE;
    assign out_ready = o.tready && rst_n;
    assign spill     = d.tkeep[DK];
    // High half is zero on a header-only beat and on the flush beat
    assign pad       = st == FLUSH || (idle && !has_data);
    assign out_valid = rst_n && (st == FLUSH || (idle && h.tvalid && (!has_data || d.tvalid)) || (st == DATA && d.tvalid));
    assign fire      = out_valid && out_ready;

    assign h.tready = idle && out_ready && (!has_data || d.tvalid);
    assign d.tready = out_ready && ((idle && h.tvalid && has_data) || st == DATA);

    assign o.tvalid       = out_valid;
    assign o.tdata        = {pad ? {DW{1'b0}} : d.tdata[DW-1:0], idle ? hdr : carry};
    assign o.tkeep        = {pad ? {DK{1'b0}} : d.tkeep[DK-1:0], idle ? {HK{1'b1}} : carry_keep};
    assign o.tlast        = pad || (d.tlast && !spill);
    assign o.tuser_vendor = idle ? h.tuser_vendor : '0;

    assign unused_ok = &{1'b0, h.tlast, h.tkeep, h.tdata[TDATA_WIDTH-1:HDR_WIDTH], d.tuser_vendor};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= IDLE;
            carry_keep <= '0;
        end else if (fire) begin
            if (st == FLUSH) begin
                st <= IDLE;
            end else if (!idle || has_data) begin
                carry      <= d.tdata[DW +: HDR_WIDTH];
                carry_keep <= d.tkeep[DK +: HK];
                st         <= !d.tlast ? DATA : spill ? FLUSH : IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ofs_fim_pcie_hdr_merge.sv
// tb_ofs_fim_pcie_hdr_merge: directed and randomized checks of header/payload merging
// against a byte-stream model (header bytes followed by payload bytes, cut into 64B beats).
module tb_ofs_fim_pcie_hdr_merge;
    typedef logic [586:0] beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    beat_t got [$];

    always #5 clk = ~clk;

    pcie_ss_axis_if #(.DATA_W(512), .USER_W(10)) hs ();
    pcie_ss_axis_if #(.DATA_W(512), .USER_W(10)) ds ();
    pcie_ss_axis_if #(.DATA_W(512), .USER_W(10)) os ();

    ofs_fim_pcie_hdr_merge #(.PL_DEPTH_OUT(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hdr_stream_source(hs),
        .data_stream_source(ds),
        .stream_sink(os)
    );

    always @(negedge clk) if (rst_n && os.tvalid && os.tready) got.push_back({os.tuser_vendor, os.tlast, os.tkeep, os.tdata});

    function automatic beat_t mk(input logic [9:0] u, input logic l, input logic [63:0] k, input logic [511:0] d);
        return {u, l, k, d};
    endfunction

    function automatic logic [255:0] rnd_hdr(input logic [7:0] fmt);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        r[7:0] = fmt;
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic put_hdr(input logic [511:0] t, input logic [9:0] u);
        int n = 0;
        hs.tdata = t;
        hs.tuser_vendor = u;
        hs.tlast = $urandom_range(0, 1);
        hs.tvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!hs.tready && n < 500);
        if (!hs.tready) begin n_cmp++; n_bad++; $display("FAIL hdr_accept got=no_tready want=tready within 500 cycles"); end
        @(posedge clk);
        #1 hs.tvalid = 1'b0;
    endtask

    task automatic put_data(input logic [511:0] t, input logic [63:0] k, input logic l);
        int n = 0;
        ds.tdata = t;
        ds.tkeep = k;
        ds.tlast = l;
        ds.tvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!ds.tready && n < 500);
        if (!ds.tready) begin n_cmp++; n_bad++; $display("FAIL data_accept got=no_tready want=tready within 500 cycles"); end
        @(posedge clk);
        #1 ds.tvalid = 1'b0;
    endtask

    task automatic test_reset();
        hs.tdata = {256'd0, rnd_hdr(8'h60)};
        hs.tvalid = 1'b1;
        ds.tvalid = 1'b1;
        ds.tkeep = '1;
        ds.tlast = 1'b1;
        os.tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (os.tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got=%b want=0", os.tvalid); end
        n_cmp++; if (hs.tready !== 1'b0) begin n_bad++; $display("FAIL reset_hdr_tready got=%b want=0", hs.tready); end
        n_cmp++; if (ds.tready !== 1'b0) begin n_bad++; $display("FAIL reset_data_tready got=%b want=0", ds.tready); end
        @(posedge clk);
        #1 hs.tvalid = 1'b0;
        ds.tvalid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL reset_no_output got=%0d want=0", got.size()); end
    endtask

    task automatic test_hdr_only();
        logic [255:0] h = rnd_hdr(8'h20);
        beat_t e [$];
        got.delete();
        put_hdr({rnd256(), h}, 10'h155);
        repeat (4) @(posedge clk);
        #1;
        e.push_back(mk(10'h155, 1'b1, 64'h0000_0000_FFFF_FFFF, {256'd0, h}));
        n_cmp++; if (got.size() != e.size()) begin n_bad++; $display("FAIL hdr_only_count got=%0d want=%0d", got.size(), e.size()); end
        foreach (e[k]) if (k < got.size()) begin
            n_cmp++; if (got[k] !== e[k]) begin n_bad++; $display("FAIL hdr_only_beat%0d got=%h want=%h", k, got[k], e[k]); end
        end
    endtask

    task automatic test_mwr_single();
        logic [255:0] h1 = rnd_hdr(8'h60);
        logic [255:0] h2 = rnd_hdr(8'h40);
        logic [511:0] d1 = {256'd0, rnd256()};
        logic [511:0] d2 = {rnd256(), rnd256()};
        beat_t e [$];
        got.delete();
        fork
            put_hdr({256'd0, h1}, 10'h0A1);
            put_data(d1, 64'h0000_0000_FFFF_FFFF, 1'b1);
        join
        fork
            put_hdr({256'd0, h2}, 10'h0B2);
            put_data(d2, '1, 1'b1);
        join
        repeat (4) @(posedge clk);
        #1;
        e.push_back(mk(10'h0A1, 1'b1, '1, {d1[255:0], h1}));
        e.push_back(mk(10'h0B2, 1'b0, '1, {d2[255:0], h2}));
        e.push_back(mk(10'h000, 1'b1, 64'h0000_0000_FFFF_FFFF, {256'd0, d2[511:256]}));
        n_cmp++; if (got.size() != e.size()) begin n_bad++; $display("FAIL mwr_single_count got=%0d want=%0d", got.size(), e.size()); end
        foreach (e[k]) if (k < got.size()) begin
            n_cmp++; if (got[k] !== e[k]) begin n_bad++; $display("FAIL mwr_single_beat%0d got=%h want=%h", k, got[k], e[k]); end
        end
    endtask

    task automatic test_mwr_96();
        logic [255:0] h = rnd_hdr(8'h4A);
        logic [511:0] d0 = {rnd256(), rnd256()};
        logic [511:0] d1 = {256'd0, rnd256()};
        beat_t e [$];
        got.delete();
        fork
            put_hdr({256'd0, h}, 10'h3C3);
            begin
                put_data(d0, '1, 1'b0);
                put_data(d1, 64'h0000_0000_FFFF_FFFF, 1'b1);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        e.push_back(mk(10'h3C3, 1'b0, '1, {d0[255:0], h}));
        e.push_back(mk(10'h000, 1'b1, '1, {d1[255:0], d0[511:256]}));
        n_cmp++; if (got.size() != e.size()) begin n_bad++; $display("FAIL mwr_96_count got=%0d want=%0d", got.size(), e.size()); end
        foreach (e[k]) if (k < got.size()) begin
            n_cmp++; if (got[k] !== e[k]) begin n_bad++; $display("FAIL mwr_96_beat%0d got=%h want=%h", k, got[k], e[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] h [4];
        beat_t e [$];
        time t0;
        got.delete();
        foreach (h[k]) h[k] = rnd_hdr(k[0] ? 8'h0A : 8'h20);
        t0 = $time;
        foreach (h[k]) put_hdr({256'd0, h[k]}, 10'(k + 1));
        n_cmp++; if ($time - t0 != 40) begin n_bad++; $display("FAIL b2b_cycles got=%0t want=40", $time - t0); end
        repeat (4) @(posedge clk);
        #1;
        foreach (h[k]) e.push_back(mk(10'(k + 1), 1'b1, 64'h0000_0000_FFFF_FFFF, {256'd0, h[k]}));
        n_cmp++; if (got.size() != e.size()) begin n_bad++; $display("FAIL b2b_count got=%0d want=%0d", got.size(), e.size()); end
        foreach (e[k]) if (k < got.size()) begin
            n_cmp++; if (got[k] !== e[k]) begin n_bad++; $display("FAIL b2b_beat%0d got=%h want=%h", k, got[k], e[k]); end
        end
    endtask

    task automatic test_random_mix();
        logic [521:0] hq [$];
        logic [576:0] dq [$];
        beat_t eq [$];
        logic [7:0] fmts [4] = '{8'h20, 8'h60, 8'h0A, 8'h4A};
        logic       hasd [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        got.delete();
        for (int t = 0; t < 1000; t++) begin
            logic [7:0] bytes [$];
            logic [255:0] h;
            logic [511:0] db;
            logic [63:0] dk;
            logic [9:0] u;
            int sel;
            int n;
            sel = $urandom_range(0, 3);
            h = rnd_hdr(fmts[sel]);
            u = 10'($urandom());
            n = hasd[sel] ? $urandom_range(1, 256) : 0;
            bytes.delete();
            for (int i = 0; i < 32; i++) bytes.push_back(h[8*i +: 8]);
            db = '0;
            dk = '0;
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom());
                bytes.push_back(b);
                db[8*(i%64) +: 8] = b;
                dk[i%64] = 1'b1;
                if (i % 64 == 63 || i == n - 1) begin
                    dq.push_back({i == n - 1, dk, db});
                    db = '0;
                    dk = '0;
                end
            end
            hq.push_back({u, rnd256(), h});
            for (int o = 0; o < bytes.size(); o += 64) begin
                logic [511:0] ed;
                logic [63:0] ek;
                ed = '0;
                ek = '0;
                for (int i = 0; i < 64 && o + i < bytes.size(); i++) begin
                    ed[8*i +: 8] = bytes[o+i];
                    ek[i] = 1'b1;
                end
                eq.push_back(mk(o == 0 ? u : 10'd0, o + 64 >= bytes.size(), ek, ed));
            end
        end
        fork
            foreach (hq[k]) begin
                repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) begin @(posedge clk); #1; end
                put_hdr(hq[k][511:0], hq[k][521:512]);
            end
            foreach (dq[k]) begin
                repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) begin @(posedge clk); #1; end
                put_data(dq[k][511:0], dq[k][575:512], dq[k][576]);
            end
            begin
                int c = 0;
                while (got.size() < eq.size() && c < 40000) begin
                    @(posedge clk);
                    #1 os.tready = $urandom_range(0, 3) != 0;
                    c++;
                end
                os.tready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (got.size() != eq.size()) begin n_bad++; $display("FAIL random_count got=%0d want=%0d", got.size(), eq.size()); end
        foreach (eq[k]) if (k < got.size()) begin
            n_cmp++; if (got[k] !== eq[k]) begin n_bad++; $display("FAIL random_beat%0d got=%h want=%h", k, got[k], eq[k]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [255:0] h = rnd_hdr(8'h60);
        logic [255:0] h2 = rnd_hdr(8'h20);
        beat_t e [$];
        os.tready = 1'b1;
        fork
            put_hdr({256'd0, h}, 10'h111);
            begin
                put_data({rnd256(), rnd256()}, '1, 1'b0);
                put_data({rnd256(), rnd256()}, '1, 1'b0);
            end
        join
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (os.tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_mid_tvalid got=%b want=0", os.tvalid); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        got.delete();
        put_hdr({256'd0, h2}, 10'h222);
        repeat (4) @(posedge clk);
        #1;
        e.push_back(mk(10'h222, 1'b1, 64'h0000_0000_FFFF_FFFF, {256'd0, h2}));
        n_cmp++; if (got.size() != e.size()) begin n_bad++; $display("FAIL reset_mid_count got=%0d want=%0d", got.size(), e.size()); end
        foreach (e[k]) if (k < got.size()) begin
            n_cmp++; if (got[k] !== e[k]) begin n_bad++; $display("FAIL reset_mid_beat%0d got=%h want=%h", k, got[k], e[k]); end
        end
    endtask

    initial begin
        hs.tvalid = 1'b0;
        hs.tdata = '0;
        hs.tkeep = '1;
        hs.tlast = 1'b1;
        hs.tuser_vendor = '0;
        ds.tvalid = 1'b0;
        ds.tdata = '0;
        ds.tkeep = '0;
        ds.tlast = 1'b0;
        ds.tuser_vendor = '0;
        os.tready = 1'b0;
        test_reset();
        test_hdr_only();
        test_mwr_single();
        test_mwr_96();
        test_back_to_back();
        test_random_mix();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
